// File: rtl/nvio3_bfpack_pkg.sv
// Shared types and default sizes for the bitfield packer.
package nvio3_bfpack_pkg;

    localparam int unsigned DWIDTH_DEF = 128;
    localparam int unsigned FWIDTH_DEF = 64;
    // Fill counter must hold up to DWIDTH + FWIDTH - 1.
    localparam int unsigned FILL_W_DEF = $clog2(DWIDTH_DEF + FWIDTH_DEF);
    localparam int unsigned BITS_W     = 8;

    typedef enum logic [1:0] {
        StFill,
        StDrain,
        StFlush
    } state_e;

endpackage

// File: rtl/bitfield_place.sv
// Masks a field to ml+1 bits and shifts it to bit position pos in a 2*DWIDTH vector.
module bitfield_place
    import nvio3_bfpack_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned FWIDTH = FWIDTH_DEF,
    parameter int unsigned ML_W   = $clog2(FWIDTH),
    parameter int unsigned POS_W  = $clog2(DWIDTH + FWIDTH)
) (
    input  logic [FWIDTH-1:0]   val_i,
    input  logic [ML_W-1:0]     ml_i,
    input  logic [POS_W-1:0]    pos_i,
    output logic [2*DWIDTH-1:0] placed_o
);

    logic [FWIDTH-1:0]   mask;
    logic [2*DWIDTH-1:0] wide;

    // Same mask rule as the bitfield unit: bit n survives when n <= ml.
    always_comb begin
        mask = '0;
        for (int unsigned n = 0; n < FWIDTH; n++) begin
            mask[n] = (n <= 32'(ml_i));
        end
        wide     = {{(2*DWIDTH-FWIDTH){1'b0}}, val_i & mask};
        placed_o = wide << pos_i;
    end

endmodule

// File: rtl/bitfield_packer.sv
// Packs variable-width fields LSB-first into DWIDTH-bit words with last-flag flush.
module bitfield_packer
    import nvio3_bfpack_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned FWIDTH = FWIDTH_DEF,
    localparam int unsigned ML_W  = $clog2(FWIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fld_valid_i,
    output logic                fld_ready_o,
    input  logic [FWIDTH-1:0]   fld_val_i,
    input  logic [ML_W-1:0]     fld_ml_i,
    input  logic                fld_last_i,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic [DWIDTH-1:0]   word_o,
    output logic [BITS_W-1:0]   word_bits_o,
    output logic                word_last_o
);

    localparam int unsigned FILL_W = $clog2(DWIDTH + FWIDTH);
    localparam logic [FILL_W-1:0] DW_FILL = FILL_W'(DWIDTH);

    state_e              state_q, state_d;
    logic [2*DWIDTH-1:0] acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                pend_last_q, pend_last_d;

    logic                word_valid_q, word_valid_d;
    logic [DWIDTH-1:0]   word_q, word_d;
    logic [BITS_W-1:0]   word_bits_q, word_bits_d;
    logic                word_last_q, word_last_d;

    logic [2*DWIDTH-1:0] placed;
    logic [FILL_W-1:0]   fill_add, fill_sub;
    logic                fld_accept;

    bitfield_place #(
        .DWIDTH (DWIDTH),
        .FWIDTH (FWIDTH),
        .ML_W   (ML_W),
        .POS_W  (FILL_W)
    ) u_place (
        .val_i    (fld_val_i),
        .ml_i     (fld_ml_i),
        .pos_i    (fill_q),
        .placed_o (placed)
    );

    // Ready is held low during reset even though the state already reads StFill.
    assign fld_ready_o = rst_ni && (state_q == StFill) && (fill_q < DW_FILL);
    assign fld_accept  = fld_valid_i && fld_ready_o;

    // State and accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StFill;
            acc_q       <= '0;
            fill_q      <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            pend_last_q <= pend_last_d;
        end
    end

    // Next state plus accumulator update; accept and pop live in disjoint states.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        pend_last_d = pend_last_q;
        fill_add    = fill_q + FILL_W'(fld_ml_i) + FILL_W'(1);
        fill_sub    = fill_q - DW_FILL;
        unique case (state_q)
            StFill: begin
                if (fld_accept) begin
                    acc_d  = acc_q | placed;
                    fill_d = fill_add;
                    if (fill_add >= DW_FILL) begin
                        state_d     = StDrain;
                        pend_last_d = fld_last_i;
                    end else if (fld_last_i) begin
                        state_d = StFlush;
                    end
                end
            end
            StDrain: begin
                if (word_ready_i) begin
                    acc_d  = acc_q >> DWIDTH;
                    fill_d = fill_sub;
                    if (fill_sub >= DW_FILL) begin
                        state_d = StDrain;
                    end else if ((fill_sub != '0) && pend_last_q) begin
                        state_d = StFlush;
                    end else begin
                        state_d     = StFill;
                        pend_last_d = 1'b0;
                    end
                end
            end
            StFlush: begin
                if (word_ready_i) begin
                    acc_d       = '0;
                    fill_d      = '0;
                    pend_last_d = 1'b0;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Output next-values derived from the upcoming state so a word shows one cycle after accept.
    always_comb begin
        word_valid_d = (state_d != StFill);
        word_d       = '0;
        word_bits_d  = '0;
        word_last_d  = 1'b0;
        unique case (state_d)
            StDrain: begin
                word_d      = acc_d[DWIDTH-1:0];
                word_bits_d = BITS_W'(DWIDTH);
                word_last_d = pend_last_d && (fill_d == DW_FILL);
            end
            StFlush: begin
                word_d      = acc_d[DWIDTH-1:0];
                word_bits_d = BITS_W'(fill_d);
                word_last_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered word outputs; they hold while the state waits on word_ready_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_valid_q <= 1'b0;
            word_q       <= '0;
            word_bits_q  <= '0;
            word_last_q  <= 1'b0;
        end else begin
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
            word_bits_q  <= word_bits_d;
            word_last_q  <= word_last_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;
    assign word_bits_o  = word_bits_q;
    assign word_last_o  = word_last_q;

endmodule

// File: tb/tb_bitfield_packer.sv
// Scoreboard bench for bitfield_packer: a bit-level reference model queues expected words.
module tb_bitfield_packer;

    localparam int unsigned DW = 128;
    localparam int unsigned FW = 64;

    logic           clk;
    logic           rst_ni;
    logic           fld_valid_i;
    logic           fld_ready_o;
    logic [FW-1:0]  fld_val_i;
    logic [5:0]     fld_ml_i;
    logic           fld_last_i;
    logic           word_valid_o;
    logic           word_ready_i;
    logic [DW-1:0]  word_o;
    logic [7:0]     word_bits_o;
    logic           word_last_o;

    bitfield_packer #(
        .DWIDTH (DW),
        .FWIDTH (FW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fld_valid_i  (fld_valid_i),
        .fld_ready_o  (fld_ready_o),
        .fld_val_i    (fld_val_i),
        .fld_ml_i     (fld_ml_i),
        .fld_last_i   (fld_last_i),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_o       (word_o),
        .word_bits_o  (word_bits_o),
        .word_last_o  (word_last_o)
    );

    typedef struct {
        logic [DW-1:0] word;
        int            bits;
        logic          last;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [511:0] m_acc;
    int           m_fill;
    int           n_checks;
    int           n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: append masked bits, cut full words, flush remainder on last.
    task automatic model_accept(input logic [FW-1:0] v, input int ml, input logic last);
        logic [511:0] mv;
        exp_t         e;
        int           n;
        n  = ml + 1;
        mv = '0;
        for (int b = 0; b < n; b++) mv[b] = v[b];
        m_acc  = m_acc | (mv << m_fill);
        m_fill = m_fill + n;
        while (m_fill >= DW) begin
            e.word = m_acc[DW-1:0];
            e.bits = DW;
            e.last = last && (m_fill == DW);
            sb.push_back(e);
            m_acc  = m_acc >> DW;
            m_fill = m_fill - DW;
        end
        if (last && m_fill > 0) begin
            e.word = m_acc[DW-1:0];
            e.bits = m_fill;
            e.last = 1'b1;
            sb.push_back(e);
            m_acc  = '0;
            m_fill = 0;
        end
    endtask

    task automatic send_field(input logic [FW-1:0] v, input int ml, input logic last);
        bit got;
        got         = 1'b0;
        fld_valid_i = 1'b1;
        fld_val_i   = v;
        fld_ml_i    = 6'(ml);
        fld_last_i  = last;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (fld_ready_o) got = 1'b1;
        end
        if (!got) chk("fld_accept_timeout", 0, 1);
        else model_accept(v, ml, last);
        @(posedge clk);
        #1;
        fld_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !word_valid_o) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    // Output monitor: every popped word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_ni && word_valid_o && word_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("word", word_o, mon_e.word);
                chk("word_bits", DW'(word_bits_o), DW'(mon_e.bits));
                chk("word_last", DW'(word_last_o), DW'(mon_e.last));
            end
        end
    end

    always @(posedge clk) begin
        if (rst_ni && fld_valid_i) begin
            assert (int'(fld_ml_i) < FW) else $error("illegal field length code %0d", fld_ml_i);
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        m_acc        = '0;
        m_fill       = 0;
        rst_ni       = 1'b0;
        fld_valid_i  = 1'b0;
        fld_val_i    = '0;
        fld_ml_i     = '0;
        fld_last_i   = 1'b0;
        word_ready_i = 1'b1;

        // Reset state.
        #12;
        chk("rst_fld_ready", DW'(fld_ready_o), 0);
        chk("rst_word_valid", DW'(word_valid_o), 0);
        chk("rst_word", word_o, 0);
        chk("rst_word_bits", DW'(word_bits_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_fld_ready", DW'(fld_ready_o), 1);
        @(posedge clk);
        #1;

        // 1: two full-width fields make one word, visible the cycle after the second accept.
        send_field(64'h1111111111111111, 63, 1'b0);
        chk("t1_no_early_valid", DW'(word_valid_o), 0);
        send_field(64'h2222222222222222, 63, 1'b0);
        chk("t1_valid_latency", DW'(word_valid_o), 1);
        chk("t1_word", word_o, 128'h2222222222222222_1111111111111111);
        wait_drain();

        // 2: short field with last, upper bits masked away.
        send_field(64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b1);
        chk("t2_word", word_o, 128'h0F);
        chk("t2_ready_low", DW'(fld_ready_o), 0);
        @(posedge clk);
        #1;
        chk("t2_ready_back", DW'(fld_ready_o), 1);
        chk("t2_valid_clear", DW'(word_valid_o), 0);

        // 3: straddling field splits across two words.
        for (int k = 0; k < 15; k++) send_field(64'hAA, 7, 1'b0);
        send_field(64'h1234, 15, 1'b1);
        chk("t3_word1", word_o, 128'h34AAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
        wait_drain();

        // 4: backpressure holds the word and blocks further fields.
        word_ready_i = 1'b0;
        send_field(64'hA5A5A5A5A5A5A5A5, 63, 1'b0);
        send_field(64'h5A5A5A5A5A5A5A5A, 63, 1'b0);
        fld_valid_i = 1'b1;
        fld_val_i   = 64'hDEADBEEFDEADBEEF;
        fld_ml_i    = 6'd7;
        fld_last_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_valid_held", DW'(word_valid_o), 1);
            chk("t4_ready_low", DW'(fld_ready_o), 0);
            chk("t4_word_held", word_o, 128'h5A5A5A5A5A5A5A5A_A5A5A5A5A5A5A5A5);
        end
        @(posedge clk);
        #1;
        fld_valid_i  = 1'b0;
        word_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_ready_back", DW'(fld_ready_o), 1);
        chk("t4_valid_clear", DW'(word_valid_o), 0);

        // 5: exact fill with last yields one word and nothing after it.
        send_field(64'h0123456789ABCDEF, 63, 1'b0);
        send_field(64'hFEDCBA9876543210, 63, 1'b1);
        chk("t5_last", DW'(word_last_o), 1);
        chk("t5_bits", DW'(word_bits_o), 128);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2;
            chk("t5_no_extra_word", DW'(word_valid_o), 0);
        end

        // 6: asynchronous reset while a word is pending discards it.
        word_ready_i = 1'b0;
        send_field(64'h7777777777777777, 63, 1'b0);
        send_field(64'h8888888888888888, 63, 1'b0);
        chk("t6_pending", DW'(word_valid_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", DW'(word_valid_o), 0);
        chk("t6_rst_word", word_o, 0);
        chk("t6_rst_bits", DW'(word_bits_o), 0);
        chk("t6_rst_last", DW'(word_last_o), 0);
        chk("t6_rst_ready", DW'(fld_ready_o), 0);
        sb.delete();
        m_acc  = '0;
        m_fill = 0;
        @(negedge clk);
        @(negedge clk);
        rst_ni       = 1'b1;
        word_ready_i = 1'b1;
        @(posedge clk);
        #1;
        send_field(64'h5A, 7, 1'b1);
        chk("t6_word", word_o, 128'h5A);
        chk("t6_bits", DW'(word_bits_o), 8);
        wait_drain();

        chk("sb_empty", DW'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
